// File: rtl/uart_regbank_n_if.sv
// ---------------------------------------------------------------------------
// uart_regbank_n_if
// Local-bus interface between the CPU-side bus master and the UART register
// bank.
//   addr       : word address (master -> slave)
//   we / re    : write / read request (master -> slave)
//   write_data : write data (master -> slave)
//   read_data  : registered read data (slave -> master)
//   read_valid : one-cycle pulse, read_data updated (slave -> master)
// ---------------------------------------------------------------------------
interface uart_regbank_n_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;

  modport master (
    output addr, we, re, write_data,
    input  read_data, read_valid
  );

  modport slave (
    input  addr, we, re, write_data,
    output read_data, read_valid
  );
endinterface

// File: rtl/uart_regbank_n.sv
// ---------------------------------------------------------------------------
// uart_regbank_n
// CPU-facing register bank for N_CH UART channels. Channel c occupies word
// addresses 4c (CR), 4c+1 (SR), 4c+2 (TDR), 4c+3 (RDR). Global registers:
// 4*N_CH ID (VERSION, read-only), 4*N_CH+1 ERR (bit31 sticky bus error,
// [7:0] saturating unmapped-access count; any write clears), and with the
// UART_REGBANK_IRQ_EN macro defined, 4*N_CH+2 IER (per-channel rx irq enable).
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : uart_regbank_n_if slave modport (addr/we/re/write_data in,
//                  read_data/read_valid out, read latency 1 clock)
//   sr_i, rdr_i  : per-channel status / rx data words, channel c at
//                  [c*DATA_W +: DATA_W]
//   cr_o, tdr_o  : per-channel config / tx data registers, same packing
//   tx_write_o   : one-cycle tx push strobe per channel
//   rx_read_o    : one-cycle rx pop strobe per channel
//   sr_read_o    : one-cycle status-read strobe per channel
//   bus_err_o    : sticky unmapped-access flag
//   irq_o        : registered combined rx interrupt (UART_REGBANK_IRQ_EN only)
//
// Strobes and read capture fire only at an access start, so a re/we held on
// the same address pops or pushes at most one FIFO entry.
// ---------------------------------------------------------------------------
module uart_regbank_n #(
  parameter int                N_CH         = 6,
  parameter int                ADDR_W       = 22,
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] CR_INIT      = 32'h0000C000,
  parameter int                RX_RST_BIT   = 1,
  parameter int                TX_RST_BIT   = 2,
  parameter int                RX_AVAIL_BIT = 0,
  parameter logic [DATA_W-1:0] VERSION      = 32'h0002_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_regbank_n_if.slave        bus,
  input  logic [N_CH*DATA_W-1:0] sr_i,
  input  logic [N_CH*DATA_W-1:0] rdr_i,
  output logic [N_CH*DATA_W-1:0] cr_o,
  output logic [N_CH*DATA_W-1:0] tdr_o,
  output logic [N_CH-1:0]        tx_write_o,
  output logic [N_CH-1:0]        rx_read_o,
  output logic [N_CH-1:0]        sr_read_o,
`ifdef UART_REGBANK_IRQ_EN
  output logic                   irq_o,
`endif
  output logic                   bus_err_o
);

  localparam logic [ADDR_W-1:0] ID_ADDR  = ADDR_W'(4 * N_CH);
  localparam logic [ADDR_W-1:0] ERR_ADDR = ADDR_W'(4 * N_CH + 1);
`ifdef UART_REGBANK_IRQ_EN
  localparam logic [ADDR_W-1:0] IER_ADDR = ADDR_W'(4 * N_CH + 2);
`endif

  // Registers and their next-state values
  logic [DATA_W-1:0] cr_q  [N_CH];
  logic [DATA_W-1:0] cr_d  [N_CH];
  logic [DATA_W-1:0] tdr_q [N_CH];
  logic [DATA_W-1:0] tdr_d [N_CH];
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic [N_CH-1:0]   tx_write_q, tx_write_d;
  logic [N_CH-1:0]   rx_read_q, rx_read_d;
  logic [N_CH-1:0]   sr_read_q, sr_read_d;
  logic              bus_err_q, bus_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef UART_REGBANK_IRQ_EN
  logic [N_CH-1:0]   ier_q, ier_d;
  logic              irq_q, irq_d;
  logic [N_CH-1:0]   rx_avail_s;
  logic              ier_hit_s;
`endif

  // Decode / combinational helpers
  logic              access_s;
  logic              start_s;
  logic [N_CH-1:0]   cr_hit_s, sr_hit_s, tdr_hit_s, rdr_hit_s;
  logic              id_hit_s, err_hit_s, mapped_s;
  logic [DATA_W-1:0] rd_val_s;
  logic [DATA_W-1:0] err_word_s;

  // Address decode, access-start detection and read-value mux
  always_comb begin
    access_s = bus.we | bus.re;
    // A new access begins when the bus goes active or moves to another address
    start_s  = access_s & (~active_q | (bus.addr != addr_q));

    cr_hit_s  = '0;
    sr_hit_s  = '0;
    tdr_hit_s = '0;
    rdr_hit_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      cr_hit_s[c]  = (bus.addr == ADDR_W'(4 * c));
      sr_hit_s[c]  = (bus.addr == ADDR_W'(4 * c + 1));
      tdr_hit_s[c] = (bus.addr == ADDR_W'(4 * c + 2));
      rdr_hit_s[c] = (bus.addr == ADDR_W'(4 * c + 3));
    end
    id_hit_s  = (bus.addr == ID_ADDR);
    err_hit_s = (bus.addr == ERR_ADDR);

    err_word_s         = '0;
    err_word_s[DATA_W-1] = bus_err_q;
    err_word_s[7:0]    = err_cnt_q;

    // Hits are one-hot, so an AND-OR mux is sufficient
    rd_val_s = ({DATA_W{id_hit_s}}  & VERSION)
             | ({DATA_W{err_hit_s}} & err_word_s);
    for (int c = 0; c < N_CH; c++) begin
      rd_val_s = rd_val_s
               | ({DATA_W{cr_hit_s[c]}}  & cr_q[c])
               | ({DATA_W{sr_hit_s[c]}}  & sr_i[c*DATA_W +: DATA_W])
               | ({DATA_W{tdr_hit_s[c]}} & tdr_q[c])
               | ({DATA_W{rdr_hit_s[c]}} & rdr_i[c*DATA_W +: DATA_W]);
    end

    mapped_s = (|cr_hit_s) | (|sr_hit_s) | (|tdr_hit_s) | (|rdr_hit_s)
             | id_hit_s | err_hit_s;

`ifdef UART_REGBANK_IRQ_EN
    ier_hit_s = (bus.addr == IER_ADDR);
    mapped_s  = mapped_s | ier_hit_s;
    rd_val_s  = rd_val_s | ({DATA_W{ier_hit_s}} & DATA_W'(ier_q));
    for (int c = 0; c < N_CH; c++) begin
      rx_avail_s[c] = sr_i[c*DATA_W + RX_AVAIL_BIT];
    end
`endif
  end

  // Next-state logic for registers, strobes and error tracking
  always_comb begin
    active_d = access_s;
    addr_d   = bus.addr;

    for (int c = 0; c < N_CH; c++) begin
      // FIFO reset bits self-clear; a CPU write in the same cycle takes priority
      cr_d[c]             = cr_q[c];
      cr_d[c][RX_RST_BIT] = 1'b0;
      cr_d[c][TX_RST_BIT] = 1'b0;
      cr_d[c]  = (bus.we & cr_hit_s[c])  ? bus.write_data : cr_d[c];
      tdr_d[c] = (bus.we & tdr_hit_s[c]) ? bus.write_data : tdr_q[c];
    end

    // Read capture uses the pre-write register values
    read_data_d  = (start_s & bus.re) ? rd_val_s : read_data_q;
    read_valid_d = start_s & bus.re;
    tx_write_d   = {N_CH{start_s & bus.we}} & tdr_hit_s;
    rx_read_d    = {N_CH{start_s & bus.re}} & rdr_hit_s;
    sr_read_d    = {N_CH{start_s & bus.re}} & sr_hit_s;

    if (bus.we && err_hit_s) begin
      bus_err_d = 1'b0;
      err_cnt_d = 8'd0;
    end else if (start_s && !mapped_s) begin
      bus_err_d = 1'b1;
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);
    end else begin
      bus_err_d = bus_err_q;
      err_cnt_d = err_cnt_q;
    end

`ifdef UART_REGBANK_IRQ_EN
    ier_d = (bus.we & ier_hit_s) ? bus.write_data[N_CH-1:0] : ier_q;
    irq_d = |(ier_q & rx_avail_s);
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        cr_q[c]  <= CR_INIT;
        tdr_q[c] <= '0;
      end
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      tx_write_q   <= '0;
      rx_read_q    <= '0;
      sr_read_q    <= '0;
      bus_err_q    <= 1'b0;
      err_cnt_q    <= 8'd0;
      active_q     <= 1'b0;
      addr_q       <= '0;
`ifdef UART_REGBANK_IRQ_EN
      ier_q        <= '0;
      irq_q        <= 1'b0;
`endif
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        cr_q[c]  <= cr_d[c];
        tdr_q[c] <= tdr_d[c];
      end
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      tx_write_q   <= tx_write_d;
      rx_read_q    <= rx_read_d;
      sr_read_q    <= sr_read_d;
      bus_err_q    <= bus_err_d;
      err_cnt_q    <= err_cnt_d;
      active_q     <= active_d;
      addr_q       <= addr_d;
`ifdef UART_REGBANK_IRQ_EN
      ier_q        <= ier_d;
      irq_q        <= irq_d;
`endif
    end
  end

  // Output packing
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      cr_o[c*DATA_W +: DATA_W]  = cr_q[c];
      tdr_o[c*DATA_W +: DATA_W] = tdr_q[c];
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;
  assign tx_write_o     = tx_write_q;
  assign rx_read_o      = rx_read_q;
  assign sr_read_o      = sr_read_q;
  assign bus_err_o      = bus_err_q;
`ifdef UART_REGBANK_IRQ_EN
  assign irq_o          = irq_q;
`endif

endmodule

// File: tb/tb_uart_regbank_n.sv
// ---------------------------------------------------------------------------
// tb_uart_regbank_n
// Directed self-checking bench for uart_regbank_n with default parameters
// (6 channels, 22-bit address, 32-bit data). Define UART_REGBANK_IRQ_EN to
// also exercise the IER/irq option.
// ---------------------------------------------------------------------------
module tb_uart_regbank_n;
  localparam int N_CH   = 6;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int VW     = N_CH * DATA_W;

  logic          clk;
  logic          rst;
  logic [VW-1:0] sr_v;
  logic [VW-1:0] rdr_v;
  logic [VW-1:0] cr_w;
  logic [VW-1:0] tdr_w;
  logic [N_CH-1:0] tx_write_w;
  logic [N_CH-1:0] rx_read_w;
  logic [N_CH-1:0] sr_read_w;
  logic          bus_err_w;
`ifdef UART_REGBANK_IRQ_EN
  logic          irq_w;
`endif

  int checks;
  int failures;

  uart_regbank_n_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  uart_regbank_n dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .sr_i       (sr_v),
    .rdr_i      (rdr_v),
    .cr_o       (cr_w),
    .tdr_o      (tdr_w),
    .tx_write_o (tx_write_w),
    .rx_read_o  (rx_read_w),
    .sr_read_o  (sr_read_w),
`ifdef UART_REGBANK_IRQ_EN
    .irq_o      (irq_w),
`endif
    .bus_err_o  (bus_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.we = 1'b0;
    bus_if.re = 1'b0;
    step();
  endtask

  // Single-cycle read; returns the captured word one clock later
  task automatic rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    bus_if.addr = a;
    bus_if.re   = 1'b1;
    bus_if.we   = 1'b0;
    step();
    d = bus_if.read_data;
    bus_if.re = 1'b0;
    step();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus_if.addr       = a;
    bus_if.write_data = d;
    bus_if.we         = 1'b1;
    bus_if.re         = 1'b0;
    step();
    bus_if.we = 1'b0;
    step();
  endtask

  initial begin
    logic [VW-1:0]     exp_cr;
    logic [DATA_W-1:0] d;
    int                pulses;

    checks   = 0;
    failures = 0;
    sr_v  = '0;
    rdr_v = '0;
    bus_if.addr       = '0;
    bus_if.we         = 1'b0;
    bus_if.re         = 1'b0;
    bus_if.write_data = '0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    for (int c = 0; c < N_CH; c++) exp_cr[c*DATA_W +: DATA_W] = 32'h0000C000;
    check_eq("rst_cr", cr_w, exp_cr);
    check_eq("rst_tdr", tdr_w, '0);
    check_eq("rst_rdata", VW'(bus_if.read_data), '0);
    check_eq("rst_strobes", VW'({bus_if.read_valid, tx_write_w, rx_read_w, sr_read_w, bus_err_w}), '0);

    // Held TDR write on ch1: one push strobe
    bus_if.addr       = 22'd6;
    bus_if.write_data = 32'h41;
    bus_if.we         = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin
        check_eq("tx_first", VW'(tx_write_w), VW'(6'b000010));
        check_eq("tdr1_first", VW'(tdr_w[1*DATA_W +: DATA_W]), VW'(32'h41));
      end
      pulses += int'(tx_write_w[1]);
    end
    idle();
    pulses += int'(tx_write_w[1]);
    check_eq("tx_pulses", VW'(pulses), VW'(1));
    check_eq("tdr1", VW'(tdr_w[1*DATA_W +: DATA_W]), VW'(32'h41));

    // Held RDR read on ch0 with changing rx data: one pop, first word kept
    bus_if.addr = 22'd3;
    bus_if.re   = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      rdr_v[0 +: DATA_W] = 32'h100 + 32'(i);
      step();
      if (i == 0) begin
        check_eq("rdr_valid_first", VW'(bus_if.read_valid), VW'(1'b1));
        check_eq("rdr_rxread_first", VW'(rx_read_w), VW'(6'b000001));
      end
      pulses += int'(rx_read_w[0]) + int'(bus_if.read_valid);
    end
    idle();
    pulses += int'(rx_read_w[0]) + int'(bus_if.read_valid);
    check_eq("rdr_pulses", VW'(pulses), VW'(2));
    check_eq("rdr_data", VW'(bus_if.read_data), VW'(32'h100));

    // CR2 self-clearing FIFO reset bits
    bus_if.addr       = 22'd8;
    bus_if.write_data = 32'h0000C006;
    bus_if.we         = 1'b1;
    step();
    check_eq("cr2_written", VW'(cr_w[2*DATA_W +: DATA_W]), VW'(32'h0000C006));
    idle();
    check_eq("cr2_selfclr", VW'(cr_w[2*DATA_W +: DATA_W]), VW'(32'h0000C000));

    // Simultaneous we+re on CR0: read sees the pre-write value
    bus_if.addr       = 22'd0;
    bus_if.write_data = 32'h00001230;
    bus_if.we         = 1'b1;
    bus_if.re         = 1'b1;
    step();
    check_eq("wr_rd_old", VW'(bus_if.read_data), VW'(32'h0000C000));
    check_eq("wr_rd_new", VW'(cr_w[0 +: DATA_W]), VW'(32'h00001230));
    idle();

    // SR read on ch1 and its strobe
    sr_v[1*DATA_W +: DATA_W] = 32'hABCD;
    bus_if.addr = 22'd5;
    bus_if.re   = 1'b1;
    step();
    check_eq("sr1_data", VW'(bus_if.read_data), VW'(32'hABCD));
    check_eq("sr1_strobe", VW'(sr_read_w), VW'(6'b000010));
    idle();
    sr_v = '0;

    rd(22'd6, d);
    check_eq("tdr1_read", VW'(d), VW'(32'h41));
    rd(22'd24, d);
    check_eq("id_read", VW'(d), VW'(32'h0002_0000));
    check_eq("no_err_yet", VW'(bus_err_w), VW'(1'b0));

    // 300 unmapped reads saturate the error counter
    for (int i = 0; i < 300; i++) rd(22'h3FFF00, d);
    check_eq("unmapped_rdata", VW'(d), VW'(0));
    check_eq("bus_err_set", VW'(bus_err_w), VW'(1'b1));
    rd(22'd25, d);
    check_eq("err_sat", VW'(d), VW'(32'h800000FF));
    wr(22'd25, 32'h0);
    rd(22'd25, d);
    check_eq("err_clr", VW'(d), VW'(0));
    check_eq("bus_err_clr", VW'(bus_err_w), VW'(1'b0));

`ifdef UART_REGBANK_IRQ_EN
    // IER enables ch3 rx-available interrupt with one cycle of latency
    sr_v[3*DATA_W +: DATA_W] = 32'h1;
    bus_if.addr       = 22'd26;
    bus_if.write_data = 32'h8;
    bus_if.we         = 1'b1;
    step();
    check_eq("irq_lat", VW'(irq_w), VW'(1'b0));
    idle();
    check_eq("irq_set", VW'(irq_w), VW'(1'b1));
    rd(22'd26, d);
    check_eq("ier_read", VW'(d), VW'(32'h8));
    wr(22'd26, 32'h0);
    step();
    check_eq("irq_clr", VW'(irq_w), VW'(1'b0));
    check_eq("ier_no_err", VW'(bus_err_w), VW'(1'b0));
    sr_v = '0;
`else
    // Without the option the IER address is unmapped
    rd(22'd26, d);
    check_eq("ier_unmapped", VW'(bus_err_w), VW'(1'b1));
    rd(22'd25, d);
    check_eq("ier_err_cnt", VW'(d), VW'(32'h80000001));
`endif

    // Reset in the middle of a held read; access restarts after release
    rdr_v[0 +: DATA_W] = 32'h55;
    bus_if.addr = 22'd3;
    bus_if.re   = 1'b1;
    step();
    check_eq("mid_first", VW'(bus_if.read_valid), VW'(1'b1));
    rst = 1'b1;
    step();
    check_eq("mid_rst", VW'({bus_if.read_valid, rx_read_w, bus_err_w}), VW'(0));
    check_eq("mid_rst_cr0", VW'(cr_w[0 +: DATA_W]), VW'(32'h0000C000));
    rst = 1'b0;
    rdr_v[0 +: DATA_W] = 32'h66;
    step();
    check_eq("mid_restart", VW'({bus_if.read_valid, rx_read_w[0]}), VW'(2'b11));
    check_eq("mid_data", VW'(bus_if.read_data), VW'(32'h66));
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
